// File: rtl/cve2_prefetch_ctrl.sv
// ============================================================================
// cve2_prefetch_ctrl: instruction-fetch bus requester with outstanding-request
// tracking and discard of stale responses after a branch.  Rev 1.0
// ============================================================================
`default_nettype none

module cve2_prefetch_ctrl #(
  parameter int unsigned NUM_REQS = 2  // 1..4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         addr_i,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  output logic                fifo_valid_o,
  output logic                fifo_clear_o,
  output logic [31:0]         fifo_addr_o,
  output logic                busy_o
);

  logic [NUM_REQS-1:0] outstanding_q, outstanding_rev, outstanding_set;
  logic [NUM_REQS-1:0] discard_q, discard_set, next_slot;
  logic [NUM_REQS:0]   therm_ext;
  logic [31:0]         fetch_addr_q, stored_addr_q, branch_addr;
  logic                valid_req_q, fifo_ready, grant, rvalid_ok;

  always_comb begin
    outstanding_rev = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      outstanding_rev[i] = outstanding_q[NUM_REQS-1-i];
    end
  end

  // FIFO free space must cover every request already in flight.
  assign fifo_ready  = ~(&(fifo_busy_i | outstanding_rev));
  assign branch_addr = {addr_i[31:2], 2'b00};

  assign instr_req_o  = valid_req_q |
                        (req_i & (fifo_ready | branch_i) & ~outstanding_q[NUM_REQS-1]);
  assign instr_addr_o = branch_i    ? branch_addr   :
                        valid_req_q ? stored_addr_q : fetch_addr_q;
  assign grant        = instr_req_o & instr_gnt_i;

  // A response with nothing in flight is spurious and must not move any state.
  assign rvalid_ok    = instr_rvalid_i & outstanding_q[0];

  // Lowest clear bit of the thermometer code is the slot a new grant takes.
  assign therm_ext       = {outstanding_q, 1'b1};
  assign next_slot       = therm_ext[NUM_REQS-1:0] & ~outstanding_q;
  assign outstanding_set = outstanding_q | (grant ? next_slot : '0);
  assign discard_set     = branch_i ? (discard_q | outstanding_q) : discard_q;

  assign fifo_valid_o = rvalid_ok & ~discard_q[0];
  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = addr_i;
  assign busy_o       = (|outstanding_q) | valid_req_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
      discard_q     <= '0;
      fetch_addr_q  <= '0;
      stored_addr_q <= '0;
      valid_req_q   <= 1'b0;
    end else begin
      outstanding_q <= rvalid_ok ? (outstanding_set >> 1) : outstanding_set;
      discard_q     <= rvalid_ok ? (discard_set >> 1) : discard_set;

      if (grant) begin
        valid_req_q <= 1'b0;
      end else if (instr_req_o) begin
        valid_req_q   <= 1'b1;
        stored_addr_q <= instr_addr_o;
      end

      if (grant) begin
        fetch_addr_q <= instr_addr_o + 32'd4;
      end else if (branch_i) begin
        fetch_addr_q <= branch_addr;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cve2_prefetch_ctrl.sv
// ============================================================================
// tb_cve2_prefetch_ctrl: directed self-checking bench for cve2_prefetch_ctrl.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cve2_prefetch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i, branch_i, instr_gnt_i, instr_rvalid_i;
  logic [31:0] addr_i;
  logic [1:0]  fifo_busy_i;
  logic        instr_req_o, fifo_valid_o, fifo_clear_o, busy_o;
  logic [31:0] instr_addr_o, fifo_addr_o;

  int n_total = 0;
  int n_bad   = 0;

  cve2_prefetch_ctrl #(.NUM_REQS(2)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .addr_i         (addr_i),
    .fifo_busy_i    (fifo_busy_i),
    .instr_req_o    (instr_req_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_addr_o   (instr_addr_o),
    .instr_rvalid_i (instr_rvalid_i),
    .fifo_valid_o   (fifo_valid_o),
    .fifo_clear_o   (fifo_clear_o),
    .fifo_addr_o    (fifo_addr_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Apply inputs shortly after a rising edge, then let combinational outputs settle.
  task automatic drive(input logic req, input logic br, input logic [31:0] addr,
                       input logic gnt, input logic rv);
    req_i = req; branch_i = br; addr_i = addr; instr_gnt_i = gnt; instr_rvalid_i = rv;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0; fifo_busy_i = 2'b00;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    #10;
    chk("rst_req",    {31'b0, instr_req_o},  32'd0);
    chk("rst_fvalid", {31'b0, fifo_valid_o}, 32'd0);
    chk("rst_busy",   {31'b0, busy_o},       32'd0);
    tick();
    rst_ni = 1'b1;

    // Branch to 0x100 granted immediately
    drive(1'b1, 1'b1, 32'h100, 1'b1, 1'b0);
    chk("br_req",   {31'b0, instr_req_o},  32'd1);
    chk("br_addr",  instr_addr_o,          32'h100);
    chk("br_clear", {31'b0, fifo_clear_o}, 32'd1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("br_next_addr", instr_addr_o,             32'h104);
    chk("br_outst",     {30'b0, dut.outstanding_q}, 32'h1);
    chk("br_busy",      {31'b0, busy_o},          32'd1);
    chk("br_clear_off", {31'b0, fifo_clear_o},    32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("br_resp", {31'b0, fifo_valid_o}, 32'd1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("br_idle_busy", {31'b0, busy_o}, 32'd0);

    // Unaligned target 0x102
    drive(1'b1, 1'b1, 32'h102, 1'b1, 1'b0);
    chk("ua_addr",  instr_addr_o,          32'h100);
    chk("ua_faddr", fifo_addr_o,           32'h102);
    chk("ua_clear", {31'b0, fifo_clear_o}, 32'd1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("ua_clear_off", {31'b0, fifo_clear_o}, 32'd0);
    tick();

    // Grant stall at 0x104 for three cycles, grant on the fourth
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("st_req",  {31'b0, instr_req_o}, 32'd1);
      chk("st_addr", instr_addr_o,         32'h104);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("st_held_req",  {31'b0, instr_req_o}, 32'd1);
    chk("st_held_addr", instr_addr_o,         32'h104);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("st_fetch", dut.fetch_addr_q, 32'h108);
    chk("st_req_off", {31'b0, instr_req_o}, 32'd0);

    // Outstanding limit: second grant fills both slots
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("lim_addr", instr_addr_o, 32'h108);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("lim_outst", {30'b0, dut.outstanding_q}, 32'h3);
    chk("lim_block", {31'b0, instr_req_o},       32'd0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("lim_resp", {31'b0, fifo_valid_o}, 32'd1);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("lim_reissue", {31'b0, instr_req_o}, 32'd1);
    chk("lim_raddr",   instr_addr_o,         32'h10C);
    tick();

    // Discard: two in flight, branch to 0x200 (blocked by the limit)
    drive(1'b1, 1'b1, 32'h200, 1'b0, 1'b0);
    chk("dc_block_br", {31'b0, instr_req_o}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("dc_resp1", {31'b0, fifo_valid_o}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("dc_resp2", {31'b0, fifo_valid_o}, 32'd0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("dc_new_addr", instr_addr_o, 32'h200);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("dc_resp3", {31'b0, fifo_valid_o}, 32'd1);
    tick();

    // FIFO occupancy gating (nothing in flight)
    fifo_busy_i = 2'b11;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("ff_full", {31'b0, instr_req_o}, 32'd0);
    fifo_busy_i = 2'b01;
    #1;
    chk("ff_room", {31'b0, instr_req_o}, 32'd1);
    fifo_busy_i = 2'b00;

    // Address wrap
    drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("wrap_addr",  instr_addr_o,     32'h0);
    chk("wrap_fetch", dut.fetch_addr_q, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();

    // Spurious response with nothing outstanding
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("sp_fvalid", {31'b0, fifo_valid_o}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("sp_outst", {30'b0, dut.outstanding_q}, 32'h0);

    // Reset mid-transaction drops tracking
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst_ni = 1'b0;
    #1;
    chk("mr_busy", {31'b0, busy_o},      32'd0);
    chk("mr_req",  {31'b0, instr_req_o}, 32'd0);
    tick();
    rst_ni = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("mr_resp", {31'b0, fifo_valid_o}, 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
